// File: rtl/vram_mp_pkg.sv
// Shared types and geometry helpers for the dual-port video RAM model.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package vram_mp_pkg;

  // Cycle type chosen from OE/WE at the RAS fall; held until the next RAS fall.
  typedef enum logic [1:0] {
    NORMAL     = 2'd0,
    MASKED_WR  = 2'd1,
    READ_XFER  = 2'd2,
    WRITE_XFER = 2'd3
  } cyc_e;

  // Word-select bits inside one SAM segment.
  function automatic int sam_lg(input int depth);
    return $clog2(depth);
  endfunction

  // Address bits needed to pick one SAM-wide segment of the array.
  function automatic int seg_aw(input int row_w, input int col_w, input int depth);
    return row_w + col_w - sam_lg(depth);
  endfunction

  // Segment address width for the default 8/8/4 geometry.
  localparam int SEG_AW_DEF = seg_aw(8, 8, 4);

endpackage

// File: rtl/vram_mp_if.sv
// VRAM bus bundle: random-port strobes/address/data and the serial port.
// Latency: n/a (wires only).
// Backpressure: none; strobes are level signals sampled on MCLK.
// master = VDP side, slave = memory side.
interface vram_mp_if #(
  parameter int DATA_W = 8,
  parameter int AD_W   = 8
);
  logic              RAS;
  logic              CAS;
  logic              WE;
  logic              OE;
  logic              SC;
  logic              SE;
  logic [AD_W-1:0]   AD;
  logic [DATA_W-1:0] RD_i;
  logic [DATA_W-1:0] RD_o;
  logic              RD_d;
  logic [DATA_W-1:0] SD_o;
  logic              SD_d;

  modport master (
    output RAS, CAS, WE, OE, SC, SE, AD, RD_i,
    input  RD_o, RD_d, SD_o, SD_d
  );

  modport slave (
    input  RAS, CAS, WE, OE, SC, SE, AD, RD_i,
    output RD_o, RD_d, SD_o, SD_d
  );
endinterface

// File: rtl/vram_mp_array.sv
// Behavioural segment-wide RAM with per-word enables and per-bit write mask.
// Latency: 1 MCLK synchronous read; writes land on the same edge.
// Backpressure: none; accepts a write and a read every cycle, no reset.
// Ports: MCLK; wr_vld/wr_dat/wr_be/wr_bm write controls; addr shared; rd_dat read data.
module vram_mp_array #(
  parameter int DATA_W = 8,
  parameter int WORDS  = 4,
  parameter int AW     = 14
) (
  input  logic                    MCLK,
  input  logic                    wr_vld,
  input  logic [AW-1:0]           addr,
  input  logic [DATA_W*WORDS-1:0] wr_dat,
  input  logic [WORDS-1:0]        wr_be,
  input  logic [DATA_W*WORDS-1:0] wr_bm,
  output logic [DATA_W*WORDS-1:0] rd_dat
);
  localparam int SEG_W = DATA_W * WORDS;

  logic [SEG_W-1:0] mem [2**AW];
  logic [SEG_W-1:0] bit_en;

  // A bit is written only when both its word enable and its mask bit are set.
  always_comb begin
    bit_en = '0;
    for (int w = 0; w < WORDS; w++) begin
      bit_en[w*DATA_W +: DATA_W] = {DATA_W{wr_be[w]}} & wr_bm[w*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge MCLK) begin
    if (wr_vld) begin
      mem[addr] <= (wr_dat & bit_en) | (mem[addr] & ~bit_en);
    end
    rd_dat <= mem[addr];
  end
endmodule

// File: rtl/vram_mp.sv
// Dual-port VRAM model: RAS/CAS random port plus SC-clocked serial (SAM) port.
// Latency: random write 1 MCLK after column latch; read data from 2nd edge after CAS fall.
// Backpressure: none; strobes sampled every MCLK, outputs tri-state flags RD_d/SD_d.
// Ports: MCLK, RESET_N (async active low), bus (vram_mp_if.slave).
// Optional: define VRAM_WRITE_MASK_EN to latch a per-bit write mask at RAS fall.
module vram_mp
  import vram_mp_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ROW_W     = 8,
  parameter int COL_W     = 8,
  parameter int SAM_DEPTH = 4
) (
  input  logic      MCLK,
  input  logic      RESET_N,
  vram_mp_if.slave  bus
);
  localparam int SAM_LG = sam_lg(SAM_DEPTH);
  localparam int SEG_W  = DATA_W * SAM_DEPTH;
  localparam int SEG_AW = seg_aw(ROW_W, COL_W, SAM_DEPTH);

  logic              ras_q, cas_q, oe_q, sc_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  cyc_e              cyc_q, cyc_d;
  logic              done_q;
  logic [SAM_LG-1:0] ptr_q;
  logic [SEG_W-1:0]  sam_q;
  logic [DATA_W-1:0] mask_q;

  logic              cas, ras_fall, cas_fall, cas_hold, oe_rise, sc_rise;
  logic              dt, wt, rnd_wr, xfer_wr, rd_drv;
  logic [SAM_LG-1:0] col_lo;
  logic [SEG_AW-1:0] seg_addr;
  logic [SEG_W-1:0]  arr_wr_dat, arr_wr_bm, arr_rd_dat;
  logic [SAM_DEPTH-1:0] arr_wr_be;

  assign cas      = ~bus.RAS & ~bus.CAS;
  assign ras_fall = ras_q & ~bus.RAS;
  assign cas_fall = ~cas_q & cas;
  assign cas_hold = cas_q & cas;
  assign oe_rise  = ~oe_q & bus.OE;
  assign sc_rise  = ~sc_q & bus.SC;
  assign dt       = (cyc_q == READ_XFER);
  assign wt       = (cyc_q == WRITE_XFER);
  assign col_lo   = col_q[SAM_LG-1:0];
  assign seg_addr = SEG_AW'({row_q, col_q} >> SAM_LG);

  assign rnd_wr  = cas_hold & ~bus.WE & ~dt & ~wt;
  // Write transfer fires once per RAS cycle; a RAS rise before CAS simply never gets here.
  assign xfer_wr = cas_hold & wt & ~done_q;

  // Cycle type register, decoded at every RAS fall.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) cyc_q <= NORMAL;
    else          cyc_q <= cyc_d;
  end

  always_comb begin
    cyc_d = cyc_q;
    if (ras_fall) begin
      case ({bus.OE, bus.WE})
        2'b01:   cyc_d = READ_XFER;
        2'b00:   cyc_d = WRITE_XFER;
        2'b10:   cyc_d = MASKED_WR;
        default: cyc_d = NORMAL;
      endcase
    end
  end

`ifdef VRAM_WRITE_MASK_EN
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N)      mask_q <= '1;
    else if (ras_fall) mask_q <= (~bus.WE & bus.OE) ? bus.RD_i : '1;
  end
`else
  assign mask_q = '1;
`endif

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ras_q  <= 1'b1;
      cas_q  <= 1'b0;
      oe_q   <= 1'b1;
      sc_q   <= 1'b1;
      row_q  <= '0;
      col_q  <= '0;
      done_q <= 1'b0;
      ptr_q  <= '0;
      sam_q  <= '0;
    end else begin
      ras_q <= bus.RAS;
      cas_q <= cas;
      oe_q  <= bus.OE;
      sc_q  <= bus.SC;
      if (ras_fall) begin
        row_q  <= bus.AD[ROW_W-1:0];
        done_q <= 1'b0;
      end
      if (cas_fall) col_q <= bus.AD[COL_W-1:0];
      if (xfer_wr)  done_q <= 1'b1;
      // A read-transfer load takes priority; a coincident SC edge is dropped.
      if (oe_rise && dt) begin
        sam_q <= arr_rd_dat;
        ptr_q <= col_lo;
      end else if (sc_rise) begin
        ptr_q <= ptr_q + SAM_LG'(1);
      end
    end
  end

  always_comb begin
    arr_wr_be = '0;
    if (xfer_wr) arr_wr_be = '1;
    else         arr_wr_be[col_lo] = 1'b1;
  end

  assign arr_wr_dat = xfer_wr ? sam_q : {SAM_DEPTH{bus.RD_i}};
  assign arr_wr_bm  = xfer_wr ? '1    : {SAM_DEPTH{mask_q}};

  vram_mp_array #(
    .DATA_W (DATA_W),
    .WORDS  (SAM_DEPTH),
    .AW     (SEG_AW)
  ) u_array (
    .MCLK   (MCLK),
    .wr_vld (rnd_wr | xfer_wr),
    .addr   (seg_addr),
    .wr_dat (arr_wr_dat),
    .wr_be  (arr_wr_be),
    .wr_bm  (arr_wr_bm),
    .rd_dat (arr_rd_dat)
  );

  assign rd_drv   = ~bus.RAS & ~bus.CAS & ~bus.OE & bus.WE & ~dt & ~wt;
  assign bus.RD_d = ~rd_drv;
  assign bus.RD_o = rd_drv ? arr_rd_dat[col_lo*DATA_W +: DATA_W] : '0;
  assign bus.SD_o = sam_q[ptr_q*DATA_W +: DATA_W];
  assign bus.SD_d = bus.SE;
endmodule

// File: doc/vram_mp.md
Name: vram_mp

Overview:
- Parametrised dual-port video RAM model: multiplexed-address random port (RAS/CAS/WE/OE) plus serial access memory (SAM) port clocked by SC.
- Generalises word width, row/column width and SAM segment depth.
- Adds write transfer (SAM -> array) and an optional per-bit write mask.
- Sits between the VDP VRAM interface and a behavioural array; all strobes are sampled on MCLK.

Parameters:
DATA_W, 8, bits per word (random and serial ports)
ROW_W, 8, row address bits latched at RAS fall
COL_W, 8, column address bits latched at CAS fall
SAM_DEPTH, 4, words per SAM segment; power of two, 2..2^COL_W; SAM_LG = log2(SAM_DEPTH)

Ports:
MCLK  in  1  system clock; all state updates on rising edge
RESET_N  in  1  asynchronous active-low reset
RAS  in  1  row strobe, active low
CAS  in  1  column strobe, active low
WE  in  1  write enable, active low
OE  in  1  output enable / transfer (DT/OE), active low
SC  in  1  serial clock; rising edge advances the pointer
SE  in  1  serial enable, active low
AD  in  max(ROW_W,COL_W)  multiplexed address
RD_i  in  DATA_W  random-port write data, and mask source
RD_o  out  DATA_W  random-port read data
RD_d  out  1  1 = random port not driving
SD_o  out  DATA_W  serial data
SD_d  out  1  1 = serial port not driving

Behaviour:
- Clocking and reset: one clock, MCLK. Reset is asynchronous, active-low, on RESET_N.
- Edge detection uses registered copies: ras_q (reset 1), cas_q (reset 0), oe_q (reset 1), sc_q (reset 1). cas = ~RAS & ~CAS.
- RAS fall (ras_q & ~RAS):
  - row <= AD[ROW_W-1:0].
  - Cycle type from OE and WE:
    - OE=0, WE=1: read transfer, dt <= 1.
    - OE=0, WE=0: write transfer, wt <= 1.
    - Otherwise: dt <= 0, wt <= 0.
  - OE=1, WE=0 latches the mask (see Optional Feature).
- CAS fall (~cas_q & cas): col <= AD[COL_W-1:0].
- Random write: on each edge with cas_q & cas & ~WE & ~dt & ~wt, word {row,col} <= (RD_i & mask) | (old & ~mask).
  - Latency 1 MCLK after the column latch.
  - Held WE writes every cycle; the last value wins.
- Random read:
  - The array has a synchronous read of the segment {row, col[COL_W-1:SAM_LG]}.
  - RD_o = selected word col[SAM_LG-1:0] when RD_d=0, else 0.
  - Data is valid from the 2nd MCLK edge after CAS fall.
  - RD_d = ~(~RAS & ~CAS & ~OE & WE & ~dt & ~wt), combinational.
- Read transfer: on an OE rise (~oe_q & OE) while dt=1, SAM <= the current segment and ptr <= col[SAM_LG-1:0].
- Write transfer:
  - On the first edge with cas_q & cas & wt, the segment {row, col[COL_W-1:SAM_LG]} <= SAM with all word enables set; the mask is ignored.
  - Occurs once per RAS cycle (done flag, cleared at RAS fall). ptr is unchanged.
- Serial pointer: on an SC rise (~sc_q & SC), ptr <= (ptr+1) mod SAM_DEPTH. It wraps within the segment, never crossing into an adjacent segment.
- Simultaneous events:
  - Read-transfer load and SC rise in the same cycle: the load wins and the SC edge is dropped.
  - RAS rising before the transfer edge cancels a pending write transfer; dt and wt stay latched until the next RAS fall.
- SD_o = SAM[ptr] (reads all-zero after reset). SD_d = SE, combinational.
- Reset values: row=0, col=0, dt=0, wt=0, done=0, ptr=0, SAM=0, mask=all ones.
- Reset outputs: RD_o=0, RD_d=1, SD_o=0. Array contents are not reset.
- Reset mid-operation: a pending write or transfer is abandoned; array writes completed before reset persist.
- Address bits of AD above ROW_W or COL_W are ignored.

Optional Feature:
VRAM_WRITE_MASK_EN
- Defined: at a RAS fall with WE=0 and OE=1, mask <= RD_i. The mask applies to random writes until the next RAS fall, which reloads it or, with WE=1, restores all ones.
- Undefined: mask is constant all ones, and WE at RAS fall has no effect beyond the cycle type.

Decomposition:
- Package vram_mp_pkg holds:
  - the cycle-type enum (NORMAL, MASKED_WR, READ_XFER, WRITE_XFER);
  - a SAM_LG function;
  - the segment-address width constant.
- Sub-module vram_mp_array: behavioural synchronous RAM of 2^(ROW_W+COL_W-SAM_LG) entries × (DATA_W·SAM_DEPTH) bits.
  - Per-word enables and per-bit mask.
  - 1-cycle read latency.
  - No reset.

Test Plan:
- Random write/read, defaults: write 0xA5 at row 0x12, col 0x37; read back -> RD_o=0xA5 two edges after CAS fall, RD_d=0; with OE=1 -> RD_d=1 and RD_o=0.
- Read transfer + serial wrap: fill row 0x03 cols 0x04..0x07 with 0x10..0x13, transfer at col 0x06 -> SD_o=0x12; SC edges give 0x13, 0x10, 0x11, 0x12 (wrap).
- Write transfer: with SAM={0x13,0x12,0x11,0x10}, write-transfer to row 0x40 col 0x08 -> random reads of cols 0x08..0x0B return 0x10..0x13; ptr unchanged.
- Transfer-vs-SC collision: OE rise and SC rise on the same edge -> ptr = col low bits, not +1.
- Mask (VRAM_WRITE_MASK_EN): mask 0x0F, old 0xFF, write 0x00 -> reads 0xF0; the next RAS cycle with WE=1 writes 0x00 -> 0x00.
- Reset mid-write-transfer: assert RESET_N low after RAS fall, before CAS -> target row unchanged; SD_o=0, RD_d=1, ptr=0.
